bus_decode: RTL

- Host-to-FPGA counterpart of the bus byte-stream encoder.
- Consumes a byte stream in the encoder's 5-byte frame format: 0x55 header, ADRH, ADRL, DATA, CKSUM.
- Validates each frame and emits one decoded bus transaction (wr, 14-bit address, 8-bit data) toward the register bus master.
- Sits between the FTDI receive path and the bus arbiter; resynchronises on framing, checksum and timeout errors.

---
 rtl/bus_decode_if.sv | 29 ++
 rtl/bus_decode.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_decode_if.sv
// Byte-stream sink, decoded-transaction source and error reporting of the
// bus frame decoder, bundled so host side and decoder share one definition.
interface bus_decode_if;
  logic        sink_stb;
  logic        sink_ack;
  logic [7:0]  sink_d;
  logic        source_stb;
  logic        source_ack;
  logic        source_wr;
  logic [13:0] source_a;
  logic [7:0]  source_d;
  logic        err_cksum;
  logic        err_frame;
  logic        err_timeout;
  logic [7:0]  err_count;

  // Host side: feeds bytes in and acknowledges decoded transactions.
  modport master (
    output sink_stb, sink_d, source_ack,
    input  sink_ack, source_stb, source_wr, source_a, source_d,
    input  err_cksum, err_frame, err_timeout, err_count
  );

  modport slave (
    input  sink_stb, sink_d, source_ack,
    output sink_ack, source_stb, source_wr, source_a, source_d,
    output err_cksum, err_frame, err_timeout, err_count
  );
endinterface

// File: rtl/bus_decode.sv
// Decodes 5-byte frames (HEADER, ADRH, ADRL, DATA, CKSUM) into single bus
// transactions; resynchronises on framing, checksum and inter-byte timeout errors.
module bus_decode #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd0,
  parameter logic [7:0]  HEADER_BYTE    = 8'h55
) (
  input logic         clk,
  input logic         rst_n,
  bus_decode_if.slave bus
);

  typedef enum logic [2:0] {
    ST_HEADER = 3'd0,
    ST_ADRH   = 3'd1,
    ST_ADRL   = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4,
    ST_OUTPUT = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sink_ack;
  logic        r_source_stb;
  logic        r_wr;
  logic [13:0] r_a;
  logic [7:0]  r_d;
  logic [7:0]  r_sum;
  logic [15:0] r_tmo_cnt;
  logic        r_err_cksum;
  logic        r_err_frame;
  logic        r_err_timeout;
  logic [7:0]  r_err_count;

  logic        w_xfer;
  logic        w_mid_frame;
  logic        w_tmo_hit;
  logic        w_err_cksum;
  logic        w_err_frame;
  logic        w_err_timeout;
  logic        w_any_err;

  function automatic logic [7:0] f_sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign w_xfer      = bus.sink_stb & r_sink_ack;
  assign w_mid_frame = (r_state == ST_ADRH) || (r_state == ST_ADRL) ||
                       (r_state == ST_DATA) || (r_state == ST_CKSUM);
  // Expiry is decided in the cycle the counter would reach the limit; a
  // byte arriving in that same cycle takes precedence.
  assign w_tmo_hit   = (TIMEOUT_CYCLES != 16'd0) && w_mid_frame && !w_xfer &&
                       (r_tmo_cnt == (TIMEOUT_CYCLES - 16'd1));
  assign w_any_err   = w_err_cksum | w_err_frame | w_err_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HEADER;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_err_cksum   = 1'b0;
    w_err_frame   = 1'b0;
    w_err_timeout = 1'b0;
    case (r_state)
      ST_HEADER: begin
        if (w_xfer && (bus.sink_d == HEADER_BYTE)) w_state_nxt = ST_ADRH;
        else                                       w_state_nxt = ST_HEADER;
      end
      ST_ADRH: begin
        if (w_xfer) begin
          if (bus.sink_d[6]) begin
            w_state_nxt = ST_HEADER;
            w_err_frame = 1'b1;
          end else begin
            w_state_nxt = ST_ADRL;
          end
        end else begin
          w_state_nxt = ST_ADRH;
        end
      end
      ST_ADRL: begin
        if (w_xfer) w_state_nxt = ST_DATA;
        else        w_state_nxt = ST_ADRL;
      end
      ST_DATA: begin
        if (w_xfer) w_state_nxt = ST_CKSUM;
        else        w_state_nxt = ST_DATA;
      end
      ST_CKSUM: begin
        if (w_xfer) begin
          if (bus.sink_d == r_sum) begin
            w_state_nxt = ST_OUTPUT;
          end else begin
            w_state_nxt = ST_HEADER;
            w_err_cksum = 1'b1;
          end
        end else begin
          w_state_nxt = ST_CKSUM;
        end
      end
      ST_OUTPUT: begin
        if (bus.source_ack) w_state_nxt = ST_HEADER;
        else                w_state_nxt = ST_OUTPUT;
      end
      default: w_state_nxt = ST_HEADER;
    endcase
    if (w_tmo_hit) begin
      w_state_nxt   = ST_HEADER;
      w_err_timeout = 1'b1;
    end else begin
      w_err_timeout = 1'b0;
    end
  end

  // Handshake levels follow the next state so they line up with it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sink_ack    <= 1'b0;
      r_source_stb  <= 1'b0;
      r_err_cksum   <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_count   <= 8'd0;
      r_tmo_cnt     <= 16'd0;
    end else begin
      r_sink_ack    <= (w_state_nxt != ST_OUTPUT);
      r_source_stb  <= (w_state_nxt == ST_OUTPUT);
      r_err_cksum   <= w_err_cksum;
      r_err_frame   <= w_err_frame;
      r_err_timeout <= w_err_timeout;
      if (w_any_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      else                                     r_err_count <= r_err_count;
      if ((TIMEOUT_CYCLES == 16'd0) || !w_mid_frame || w_xfer || w_tmo_hit) r_tmo_cnt <= 16'd0;
      else                                                                 r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= 1'b0;
      r_a   <= 14'd0;
      r_d   <= 8'd0;
      r_sum <= 8'd0;
    end else if (w_xfer) begin
      case (r_state)
        ST_HEADER: r_sum <= HEADER_BYTE;
        ST_ADRH: begin
          r_wr       <= bus.sink_d[7];
          r_a[13:8]  <= bus.sink_d[5:0];
          r_sum      <= f_sum_add(r_sum, bus.sink_d);
        end
        ST_ADRL: begin
          r_a[7:0] <= bus.sink_d;
          r_sum    <= f_sum_add(r_sum, bus.sink_d);
        end
        ST_DATA: begin
          r_d   <= bus.sink_d;
          r_sum <= f_sum_add(r_sum, bus.sink_d);
        end
        default: r_sum <= r_sum;
      endcase
    end else begin
      r_sum <= r_sum;
    end
  end

  assign bus.sink_ack    = r_sink_ack;
  assign bus.source_stb  = r_source_stb;
  assign bus.source_wr   = r_wr;
  assign bus.source_a    = r_a;
  assign bus.source_d    = r_d;
  assign bus.err_cksum   = r_err_cksum;
  assign bus.err_frame   = r_err_frame;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_count   = r_err_count;

endmodule
